led_seq_ctrl: RTL

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_pkg.sv | 60 ++++++
 rtl/led_seq_if.sv | 23 ++
 rtl/led_step_timer.sv | 32 +++
 rtl/led_seq_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer.
// LED_SEQ_PING_EN adds the PING mode to the key_mode cycle.
package led_seq_pkg;

  localparam int CNT_W = 25;
  localparam int SPD_W = 2;

  typedef enum logic [1:0] {
    MODE_ROT_R = 2'd0,
    MODE_ROT_L = 2'd1,
    MODE_PING  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } run_state_t;

  localparam logic [3:0] PAT_INIT_RIGHT = 4'b0111;
  localparam logic [3:0] PAT_INIT_LEFT  = 4'b1110;
  localparam logic [3:0] PAT_INIT_BLINK = 4'b0000;

  typedef struct packed {
    run_state_t       state;
    logic [SPD_W-1:0] spd;
    logic             dir_left;
  } dbg_t;

  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    n = MODE_ROT_R;
`ifdef LED_SEQ_PING_EN
    case (m)
      MODE_ROT_R: n = MODE_ROT_L;
      MODE_ROT_L: n = MODE_PING;
      MODE_PING:  n = MODE_BLINK;
      default:    n = MODE_ROT_R;
    endcase
`else
    case (m)
      MODE_ROT_R: n = MODE_ROT_L;
      MODE_ROT_L: n = MODE_BLINK;
      default:    n = MODE_ROT_R;
    endcase
`endif
    return n;
  endfunction

  function automatic logic [3:0] init_pattern(input mode_t m);
    logic [3:0] p;
    case (m)
      MODE_ROT_L: p = PAT_INIT_LEFT;
      MODE_BLINK: p = PAT_INIT_BLINK;
      default:    p = PAT_INIT_RIGHT;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_seq_if.sv
// Key inputs, LED outputs and debug view of the LED sequencer.
// Keys are single-cycle pulses with no back-pressure; outputs are registered.
interface led_seq_if;

  logic                  key_mode;
  logic                  key_speed;
  logic                  key_pause;
  logic [3:0]            led;
  logic [1:0]            mode;
  logic                  step_tick;
  led_seq_pkg::dbg_t     dbg;

  modport master (
    output key_mode, key_speed, key_pause,
    input  led, mode, step_tick, dbg
  );

  modport slave (
    input  key_mode, key_speed, key_pause,
    output led, mode, step_tick, dbg
  );

endinterface

// File: rtl/led_step_timer.sv
// Step period counter: counts 0..(CNT_MAX >> spd) while enabled and
// raises tick for the one cycle it sits on the limit.
module led_step_timer
  import led_seq_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = 25'd24_999_999
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [SPD_W-1:0] spd,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] limit;

  assign limit = CNT_MAX >> spd;
  assign tick  = enable & ~clear & (cnt_q == limit);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == limit) ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// Four-LED pattern sequencer with mode/speed/pause keys.
// LED_SEQ_PING_EN enables the PING mode and its direction register.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = 25'd24_999_999
) (
  input logic     sys_clk,
  input logic     sys_rst_n,
  led_seq_if.slave bus
);

  logic             mode_evt, speed_evt, pause_evt, step_evt;
  run_state_t       state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [3:0]       led_q, led_d;
  logic [SPD_W-1:0] spd_q, spd_d;
  logic             step_q;
  logic             dir_left;

  // Priority mode > speed > pause; a losing pulse is simply dropped.
  assign mode_evt  = bus.key_mode;
  assign speed_evt = bus.key_speed & ~bus.key_mode;
  assign pause_evt = bus.key_pause & ~bus.key_mode & ~bus.key_speed;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_RUN;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (pause_evt) state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
  end

  // A pause pulse freezes the counter in its own cycle, so a step due then is held over.
  led_step_timer #(.CNT_MAX(CNT_MAX)) u_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (mode_evt | speed_evt),
    .enable    ((state_q == ST_RUN) & ~pause_evt),
    .spd       (spd_q),
    .tick      (step_evt)
  );

`ifdef LED_SEQ_PING_EN
  logic dir_q, dir_d;
  assign dir_left = dir_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) dir_q <= 1'b0;
    else            dir_q <= dir_d;
  end
`else
  assign dir_left = 1'b0;
`endif

  always_comb begin
    mode_d = mode_q;
    led_d  = led_q;
    spd_d  = spd_q;
`ifdef LED_SEQ_PING_EN
    dir_d  = dir_q;
`endif
    if (mode_evt) begin
      mode_d = next_mode(mode_q);
      led_d  = init_pattern(mode_d);
`ifdef LED_SEQ_PING_EN
      dir_d  = 1'b0;
`endif
    end else if (speed_evt) begin
      spd_d = spd_q + 2'd1;
    end else if (step_evt) begin
      case (mode_q)
        MODE_ROT_R: led_d = {led_q[0], led_q[3:1]};
        MODE_ROT_L: led_d = {led_q[2:0], led_q[3]};
`ifdef LED_SEQ_PING_EN
        // Bounce at either end without repeating the end value.
        MODE_PING: begin
          if (!dir_q) begin
            if (led_q == 4'b1110) begin
              led_d = 4'b1101;
              dir_d = 1'b1;
            end else begin
              led_d = {1'b1, led_q[3:1]};
            end
          end else begin
            if (led_q == 4'b0111) begin
              led_d = 4'b1011;
              dir_d = 1'b0;
            end else begin
              led_d = {led_q[2:0], 1'b1};
            end
          end
        end
`endif
        default:    led_d = ~led_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q <= MODE_ROT_R;
      led_q  <= PAT_INIT_RIGHT;
      spd_q  <= '0;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      led_q  <= led_d;
      spd_q  <= spd_d;
      step_q <= step_evt;
    end
  end

  assign bus.led          = led_q;
  assign bus.mode         = mode_q;
  assign bus.step_tick    = step_q;
  assign bus.dbg.state    = state_q;
  assign bus.dbg.spd      = spd_q;
  assign bus.dbg.dir_left = dir_left;

endmodule
